// File: rtl/imm_ext.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext
// Purpose  : Immediate-extension unit for the MIPS datapath. Widens a 16-bit
//            instruction immediate to 32 bits in one of four modes and
//            registers the result (1-cycle latency) with a valid strobe.
// Ports    : clk   - system clock, rising-edge sampled
//            reset - synchronous, active-high reset
//            en    - load enable; imm/EOp accepted on an edge with en=1
//            imm   - raw 16-bit immediate field
//            EOp   - mode: 00 sign-ext, 01 zero-ext, 10 load-upper,
//                    11 branch offset (sign-ext, shift left 2)
//            ext   - extended immediate
//            vld   - ext holds a result from an accepted input
// Config   : EXT_COMB_OUT_EN - when defined, ext/vld are driven
//            combinationally from res/en and the register stage is removed.
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [15:0] imm,
   input  logic [1:0]  EOp,
   output logic [31:0] ext,
   output logic        vld
);

   localparam logic [1:0] C_EOP_SEXT = 2'b00;
   localparam logic [1:0] C_EOP_ZEXT = 2'b01;
   localparam logic [1:0] C_EOP_LUI  = 2'b10;
   localparam logic [1:0] C_EOP_BOFS = 2'b11;

   logic [31:0] w_res;

   // Pure bit rearrangement; every EOp value is decoded so no X can leak.
   always_comb begin
      w_res = 32'h0000_0000;
      case (EOp)
         C_EOP_SEXT: w_res = {{16{imm[15]}}, imm};
         C_EOP_ZEXT: w_res = {16'h0000, imm};
         C_EOP_LUI:  w_res = {imm, 16'h0000};
         C_EOP_BOFS: w_res = {{14{imm[15]}}, imm, 2'b00};
         default:    w_res = 32'h0000_0000;
      endcase
   end

`ifdef EXT_COMB_OUT_EN
   // Zero-latency variant: clk/reset are kept only for port compatibility.
   logic w_unused_clk_reset;
   assign w_unused_clk_reset = clk ^ reset;

   assign ext = w_res;
   assign vld = en;
`else
   logic [31:0] r_ext;
   logic        r_vld;

   // Reset dominates enable; with en=0 the result holds but vld drops, so
   // vld is a one-cycle strobe per accepted input.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ext <= 32'h0000_0000;
         r_vld <= 1'b0;
      end else if (en) begin
         r_ext <= w_res;
         r_vld <= 1'b1;
      end else begin
         r_vld <= 1'b0;
      end
   end

   assign ext = r_ext;
   assign vld = r_vld;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_ext
// Purpose  : Directed self-checking bench for imm_ext (registered build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_ext;

   logic        clk;
   logic        reset;
   logic        en;
   logic [15:0] imm;
   logic [1:0]  EOp;
   logic [31:0] ext;
   logic        vld;

   int checks   = 0;
   int failures = 0;

   imm_ext dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .imm   (imm),
      .EOp   (EOp),
      .ext   (ext),
      .vld   (vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs, take one rising edge, settle 1 time unit past it.
   task automatic step(input logic r, input logic e, input logic [1:0] op,
                       input logic [15:0] i);
      reset = r;
      en    = e;
      EOp   = op;
      imm   = i;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] exp_ext,
                      input logic exp_vld);
      checks++;
      assert (ext === exp_ext && vld === exp_vld)
      else begin
         failures++;
         $error("FAIL %s: ext=%h vld=%b expected ext=%h vld=%b",
                tag, ext, vld, exp_ext, exp_vld);
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; imm = 16'h0000; EOp = 2'b00;

      // Reset held for two cycles
      step(1'b1, 1'b0, 2'b00, 16'h0000);
      step(1'b1, 1'b0, 2'b00, 16'h0000);
      chk("reset", 32'h0000_0000, 1'b0);

      // First enabled edge after reset: zero immediate, vld strobes once
      step(1'b0, 1'b1, 2'b00, 16'h0000);
      chk("en_zero", 32'h0000_0000, 1'b1);
      step(1'b0, 1'b0, 2'b00, 16'h0000);
      chk("vld_drop", 32'h0000_0000, 1'b0);

      // Sign-extend
      step(1'b0, 1'b1, 2'b00, 16'h8001);
      chk("sext_neg", 32'hFFFF_8001, 1'b1);
      step(1'b0, 1'b1, 2'b00, 16'h7FFF);
      chk("sext_pos", 32'h0000_7FFF, 1'b1);

      // Zero-extend and load-upper
      step(1'b0, 1'b1, 2'b01, 16'h8001);
      chk("zext", 32'h0000_8001, 1'b1);
      step(1'b0, 1'b1, 2'b10, 16'h1234);
      chk("lui", 32'h1234_0000, 1'b1);

      // Hold: en=0 with changed inputs leaves ext untouched
      step(1'b0, 1'b0, 2'b10, 16'hFFFF);
      chk("hold1", 32'h1234_0000, 1'b0);
      step(1'b0, 1'b0, 2'b00, 16'h8001);
      chk("hold2", 32'h1234_0000, 1'b0);

      // Branch offset
      step(1'b0, 1'b1, 2'b11, 16'hFFFF);
      chk("bofs_m1", 32'hFFFF_FFFC, 1'b1);
      step(1'b0, 1'b1, 2'b11, 16'h4000);
      chk("bofs_4000", 32'h0001_0000, 1'b1);
      step(1'b0, 1'b1, 2'b11, 16'h8000);
      chk("bofs_8000", 32'hFFFE_0000, 1'b1);

      // Reset together with enable: reset wins
      step(1'b1, 1'b1, 2'b00, 16'hFFFF);
      chk("rst_en", 32'h0000_0000, 1'b0);
      // After release, no valid without a new enabled edge
      step(1'b0, 1'b0, 2'b00, 16'hFFFF);
      chk("post_rst", 32'h0000_0000, 1'b0);

      // Streaming through all modes, vld high throughout
      step(1'b0, 1'b1, 2'b00, 16'hF00F);
      chk("strm0", 32'hFFFF_F00F, 1'b1);
      step(1'b0, 1'b1, 2'b01, 16'hF00F);
      chk("strm1", 32'h0000_F00F, 1'b1);
      step(1'b0, 1'b1, 2'b10, 16'hF00F);
      chk("strm2", 32'hF00F_0000, 1'b1);
      step(1'b0, 1'b1, 2'b11, 16'hF00F);
      chk("strm3", 32'hFFFF_C03C, 1'b1);
      step(1'b0, 1'b0, 2'b00, 16'h0000);
      chk("strm_end", 32'hFFFF_C03C, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
